// File: rtl/rv32i_pkg.sv
// Shared morv core types; this slice holds the memory arbiter's state and owner enums.
package rv32i_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/morv_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever was not granted last.
module morv_rr_arb2
   import rv32i_pkg::*;
(
   input  logic       req_fetch,
   input  logic       req_data,
   input  arb_owner_e last_gnt,
   output logic [1:0] gnt
);

   // bit 0 = fetch, bit 1 = data; at most one bit is ever set
   assign gnt[0] = req_fetch & (~req_data | (last_gnt == DATA));
   assign gnt[1] = req_data  & (~req_fetch | (last_gnt == FETCH));

endmodule

// File: rtl/morv_mem_arbiter.sv
// Shares the single memory port between fetch and load/store, one transaction at a time,
// with a watchdog that aborts accesses memory never completes.
module morv_mem_arbiter
   import rv32i_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_write,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_valid,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam bit              WDOG_EN  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

   arb_state_e       state, state_next;
   arb_owner_e       owner, last_gnt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       pick;
   logic             grant_fetch, grant_data, complete, abort;

   morv_rr_arb2 u_pick (
      .req_fetch (i_req),
      .req_data  (d_req),
      .last_gnt  (last_gnt),
      .gnt       (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // mem_ready has priority over the watchdog when both land on the same cycle
   always_comb begin
      state_next  = state;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      complete    = 1'b0;
      abort       = 1'b0;
      case (state)
         IDLE: begin
            if (pick != 2'b00) begin
               grant_fetch = pick[0];
               grant_data  = pick[1];
               state_next  = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               complete   = 1'b1;
               state_next = RESP;
            end else if (WDOG_EN && (cnt == CNT_LAST)) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grants are gated by rst_n so every output drops the instant reset asserts
   assign i_gnt = rst_n & grant_fetch;
   assign d_gnt = rst_n & grant_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= FETCH;
         last_gnt    <= FETCH;
         cnt         <= '0;
         mem_valid   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_write   <= 1'b0;
         mem_wstrb   <= '0;
         i_rvalid    <= 1'b0;
         i_rdata     <= '0;
         i_err       <= 1'b0;
         d_rvalid    <= 1'b0;
         d_rdata     <= '0;
         d_err       <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         i_rdata  <= '0;
         i_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
         d_err    <= 1'b0;

         if (grant_fetch || grant_data) begin
            owner       <= grant_data ? DATA : FETCH;
            last_gnt    <= grant_data ? DATA : FETCH;
            cnt         <= '0;
            mem_valid   <= 1'b1;
            mem_address <= grant_data ? d_addr : i_addr;
            mem_wdata   <= grant_data ? d_wdata : '0;
            mem_write   <= grant_data & d_write;
            mem_wstrb   <= (grant_data && d_write) ? d_wstrb : 4'b0000;
         end

         // Stores and aborts return zero data so the requester never sees bus garbage
         if (complete || abort) begin
            mem_valid <= 1'b0;
            if (owner == FETCH) begin
               i_rvalid <= 1'b1;
               i_rdata  <= (complete && !mem_write) ? mem_rdata : '0;
               i_err    <= abort;
            end else begin
               d_rvalid <= 1'b1;
               d_rdata  <= (complete && !mem_write) ? mem_rdata : '0;
               d_err    <= abort;
            end
         end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/morv_mem_arbiter.md
# morv_mem_arbiter

Two-requester arbiter that shares the core's single memory port between an instruction-fetch requester and a load/store requester. It sits between the morv core's fetch/data paths and the external memory port. It accepts one transaction at a time, holds its payload stable on the memory side until `mem_ready`, and returns read data or an error to the winning requester. A watchdog aborts transactions that memory never completes.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles a transaction may wait for `mem_ready` before abort; 0 disables the watchdog.
- `CNT_W`, default 8: width of the watchdog counter; must satisfy TIMEOUT ≤ 2^CNT_W − 1.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `i_req` in 1: fetch request; held with `i_addr` stable until `i_gnt`.
- `i_addr` in 32: fetch address.
- `i_gnt` out 1: fetch request accepted this cycle.
- `i_rvalid` out 1: one-cycle pulse; `i_rdata`/`i_err` valid.
- `i_rdata` out 32: fetched word.
- `i_err` out 1: fetch aborted by watchdog.
- `d_req` in 1: data request; payload held stable until `d_gnt`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_write` in 1: 1 = store, 0 = load.
- `d_wstrb` in 4: byte strobes for stores.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse; response valid. Pulses for stores too.
- `d_rdata` out 32: load data; 0 for stores.
- `d_err` out 1: data access aborted by watchdog.
- `mem_valid` out 1: transaction presented to memory.
- `mem_address` out 32: latched address.
- `mem_wdata` out 32: latched store data; 0 for fetch.
- `mem_write` out 1: latched write flag; 0 for fetch.
- `mem_wstrb` out 4: latched strobes; 0 for reads.
- `mem_rdata` in 32: memory read data, sampled when `mem_ready`.
- `mem_ready` in 1: memory completes the presented transaction this cycle.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any request is present, assert exactly one of `i_gnt`/`d_gnt` combinationally.
  - On that edge, latch the winner's payload into the memory-side registers, record the owner, clear the counter, and go to BUSY.
  - With no request, remain in IDLE.
- **Arbitration**
  - A single requester always wins.
  - On simultaneous requests, grant the requester not granted last (`last_gnt`).
  - `last_gnt` resets to FETCH, so data wins the first tie.
  - `last_gnt` updates only on a grant.
- **BUSY**
  - `mem_valid=1`; the latched payload is held unchanged.
  - When `mem_ready` is sampled high, capture `mem_rdata` (forced to 0 if the access is a store), set err=0, and go to RESP.
  - Otherwise increment the counter.
  - If TIMEOUT≠0 and the counter equals TIMEOUT−1 while `mem_ready`=0, go to RESP with err=1 and rdata=0.
  - A `mem_ready` arriving on the same cycle as the timeout wins: normal completion.
- **RESP**
  - Pulse the owner's `*_rvalid` with the registered rdata and err.
  - The other requester's response outputs stay 0.
  - `mem_valid=0`; next state is IDLE.
  - No grant is issued in RESP.
- `mem_ready` while not in BUSY is ignored.
- Requests dropped before being granted are legal; nothing is recorded.
- Reset, including mid-transaction:
  - State goes to IDLE, `last_gnt` to FETCH, counter to 0.
  - All outputs go to 0 immediately (asynchronous).
  - The in-flight transaction is discarded; no `rvalid` is issued afterwards.

## Timing
- Grant in cycle N (IDLE).
- `mem_valid` is high from cycle N+1.
- If `mem_ready` is sampled in cycle N+k (k≥1), `*_rvalid` is high in cycle N+k+1.
- The next grant is possible in cycle N+k+2.
- Minimum: 3 cycles per transaction; response latency after grant is 2 cycles.
- Timeout response: `rvalid` in cycle N+TIMEOUT+1.
- `mem_*` payload outputs are registered; `*_gnt` is combinational from `*_req` and state.
- `*_rvalid`, `*_rdata` and `*_err` are registered.

## Structure
- Shared package `rv32i_pkg` gains:
  - `arb_state_e` enum: IDLE, BUSY, RESP.
  - `arb_owner_e` enum: FETCH, DATA.
- Sub-module `morv_rr_arb2`: combinational two-way round-robin picker.
  - Inputs: two requests and `last_gnt`.
  - Outputs: one-hot grant.
- FSM, payload registers and watchdog live in `morv_mem_arbiter`.

## Test plan
- **Fetch only:** `i_req`, `i_addr=0x100`, `mem_ready` in the first BUSY cycle with `mem_rdata=0xDEADBEEF`.
  - Expect `i_gnt` at cycle 0, `mem_valid` at cycle 1.
  - Expect `i_rvalid` with `i_rdata=0xDEADBEEF`, `i_err=0` at cycle 2.
- **Tie, then round-robin:** both requesting continuously, memory always ready.
  - Expect grant sequence D, I, D, I.
  - Expect `mem_write`/`mem_wstrb` = 0 on fetch transactions.
- **Store:** `d_addr=0x204`, `d_wdata=0x11223344`, `d_wstrb=4'b1100`, `mem_ready` delayed 3 cycles.
  - Expect payload stable for 3 cycles, then `d_rvalid` with `d_rdata=0`, `d_err=0`.
- **Watchdog:** TIMEOUT=4, `mem_ready` held 0.
  - Expect `mem_valid` high for exactly 4 cycles.
  - Expect `d_rvalid` with `d_err=1` one cycle later.
  - Rerun with `mem_ready` on the 4th cycle: expect `d_err=0`.
- **Reset mid-BUSY:** assert `rst_n=0` asynchronously during BUSY.
  - Expect all outputs 0 immediately and no `rvalid` after release.
  - Expect the first tie after release to grant data.
